// File: rtl/uart_select_writer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_select_writer_if : command handshake and selector bus bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface uart_select_writer_if;
  logic        sel_valid;
  logic        sel_ready;
  logic        sel_release;
  logic [3:0]  sel_idx;
  logic        en;
  logic [15:0] d_bus;
  logic        active;
  logic [3:0]  cur_idx;
  logic        done;
  logic        err;

  modport master (
    output sel_valid, sel_release, sel_idx,
    input  sel_ready, en, d_bus, active, cur_idx, done, err
  );

  modport slave (
    input  sel_valid, sel_release, sel_idx,
    output sel_ready, en, d_bus, active, cur_idx, done, err
  );
endinterface
`default_nettype wire

// File: rtl/uart_select_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_select_writer : sequences one-hot channel words and enable strobe
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_select_writer #(
  parameter int CHANNEL_AMOUNT = 8,
  parameter int SETUP_CYCLES   = 3,
  parameter int HOLD_CYCLES    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_select_writer_if.slave  bus
);

  localparam int CNT_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACTIVE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               en_q, en_d;
  logic [15:0]        d_bus_q, d_bus_d;
  logic [3:0]         cur_idx_q, cur_idx_d;
  logic               pend_valid_q, pend_valid_d;
  logic [3:0]         pend_idx_q, pend_idx_d;
  logic               done_pre_q, done_pre_d;
  logic               err_pre_q, err_pre_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic sel_ready;
  logic accept;
  logic idx_legal;
  logic cnt_last;

  assign sel_ready = ((state_q == S_IDLE) || (state_q == S_ACTIVE)) && !reset;
  assign accept    = bus.sel_valid && sel_ready;
  assign idx_legal = ({1'b0, bus.sel_idx} < 5'(CHANNEL_AMOUNT));
  assign cnt_last  = (cnt_q == CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    en_d         = en_q;
    d_bus_d      = d_bus_q;
    cur_idx_d    = cur_idx_q;
    pend_valid_d = pend_valid_q;
    pend_idx_d   = pend_idx_q;
    done_pre_d   = 1'b0;
    err_pre_d    = 1'b0;
    // Handshake-completion pulses surface one cycle after the accepting edge
    done_d       = done_pre_q;
    err_d        = err_pre_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.sel_release) begin
            done_pre_d = 1'b1;
          end else if (!idx_legal) begin
            err_pre_d = 1'b1;
          end else begin
            d_bus_d   = 16'h0001 << bus.sel_idx;
            cur_idx_d = bus.sel_idx;
            cnt_d     = CNT_W'(SETUP_CYCLES);
            state_d   = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (cnt_last) begin
          en_d    = 1'b1;
          done_d  = 1'b1;
          state_d = S_ACTIVE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACTIVE: begin
        if (accept) begin
          if (!bus.sel_release && idx_legal && (bus.sel_idx == cur_idx_q)) begin
            done_pre_d = 1'b1;
          end else begin
            // Illegal index degrades to a release after flagging the error
            en_d         = 1'b0;
            cnt_d        = CNT_W'(HOLD_CYCLES);
            state_d      = S_HOLD;
            err_pre_d    = !bus.sel_release && !idx_legal;
            pend_valid_d = !bus.sel_release && idx_legal;
            pend_idx_d   = bus.sel_idx;
          end
        end
      end
      S_HOLD: begin
        if (cnt_last) begin
          pend_valid_d = 1'b0;
          if (pend_valid_q) begin
            d_bus_d   = 16'h0001 << pend_idx_q;
            cur_idx_d = pend_idx_q;
            cnt_d     = CNT_W'(SETUP_CYCLES);
            state_d   = S_SETUP;
          end else begin
            d_bus_d    = 16'h0000;
            cur_idx_d  = 4'd0;
            done_pre_d = 1'b1;
            state_d    = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      en_q         <= 1'b0;
      d_bus_q      <= 16'h0000;
      cur_idx_q    <= 4'd0;
      pend_valid_q <= 1'b0;
      pend_idx_q   <= 4'd0;
      done_pre_q   <= 1'b0;
      err_pre_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      en_q         <= en_d;
      d_bus_q      <= d_bus_d;
      cur_idx_q    <= cur_idx_d;
      pend_valid_q <= pend_valid_d;
      pend_idx_q   <= pend_idx_d;
      done_pre_q   <= done_pre_d;
      err_pre_q    <= err_pre_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.sel_ready = sel_ready;
  assign bus.en        = en_q;
  assign bus.active    = en_q;
  assign bus.d_bus     = d_bus_q;
  assign bus.cur_idx   = cur_idx_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_select_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_select_writer : directed vector table, corner sequences, random soak
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_select_writer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_select_writer_if ifm ();
  uart_select_writer_if ifr ();

  uart_select_writer #(.CHANNEL_AMOUNT(8), .SETUP_CYCLES(3), .HOLD_CYCLES(3)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifm)
  );

  uart_select_writer #(.CHANNEL_AMOUNT(8), .SETUP_CYCLES(1), .HOLD_CYCLES(1)) u_dut_fast (
    .clk   (clk),
    .reset (reset),
    .bus   (ifr)
  );

  typedef struct {
    logic        rst;
    logic        v;
    logic        rel;
    logic [3:0]  idx;
    logic        rdy;
    logic        en;
    logic [15:0] d;
    logic [3:0]  cur;
    logic        dn;
    logic        er;
  } vec_t;

  vec_t vecs[$];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic add(input logic rst, input logic v, input logic rel, input logic [3:0] idx,
                     input logic rdy, input logic en, input logic [15:0] d,
                     input logic [3:0] cur, input logic dn, input logic er);
    vec_t t;
    t.rst = rst; t.v = v; t.rel = rel; t.idx = idx;
    t.rdy = rdy; t.en = en; t.d = d; t.cur = cur; t.dn = dn; t.er = er;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rel, input logic [3:0] idx);
    ifm.sel_valid   = v;
    ifm.sel_release = rel;
    ifm.sel_idx     = idx;
  endtask

  // Full observable state of the main DUT: {rdy, en, active, d_bus, cur_idx, done, err}
  function automatic logic [31:0] obs();
    return {8'd0, ifm.sel_ready, ifm.en, ifm.active, ifm.d_bus, ifm.cur_idx, ifm.done, ifm.err};
  endfunction

  function automatic logic [31:0] pack_exp(input logic rdy, input logic en, input logic [15:0] d,
                                           input logic [3:0] cur, input logic dn, input logic er);
    return {8'd0, rdy, en, en, d, cur, dn, er};
  endfunction

  logic [15:0] prev_d;
  logic        prev_en;
  int          exp_done, exp_err, seen_done, seen_err;
  logic        acc, illegal;

  initial begin
    drive(1'b0, 1'b0, 4'd0);
    ifr.sel_valid = 1'b0; ifr.sel_release = 1'b0; ifr.sel_idx = 4'd0;

    //  rst v  rel idx     rdy en d         cur  dn er
    add(1, 0, 0, 4'd0,     0, 0, 16'h0000, 4'd0, 0, 0);  // reset state
    add(0, 0, 0, 4'd0,     1, 0, 16'h0000, 4'd0, 0, 0);
    add(0, 1, 0, 4'd2,     0, 0, 16'h0004, 4'd2, 0, 0);  // select 2 at T
    add(0, 0, 0, 4'd0,     0, 0, 16'h0004, 4'd2, 0, 0);
    add(0, 0, 0, 4'd0,     0, 0, 16'h0004, 4'd2, 0, 0);
    add(0, 0, 0, 4'd0,     1, 1, 16'h0004, 4'd2, 1, 0);  // en + done at T+3
    add(0, 0, 0, 4'd0,     1, 1, 16'h0004, 4'd2, 0, 0);
    add(0, 1, 0, 4'd5,     0, 0, 16'h0004, 4'd2, 0, 0);  // switch to 5
    add(0, 0, 0, 4'd0,     0, 0, 16'h0004, 4'd2, 0, 0);
    add(0, 0, 0, 4'd0,     0, 0, 16'h0004, 4'd2, 0, 0);
    add(0, 0, 0, 4'd0,     0, 0, 16'h0020, 4'd5, 0, 0);  // bus moves at T+3
    add(0, 0, 0, 4'd0,     0, 0, 16'h0020, 4'd5, 0, 0);
    add(0, 0, 0, 4'd0,     0, 0, 16'h0020, 4'd5, 0, 0);
    add(0, 0, 0, 4'd0,     1, 1, 16'h0020, 4'd5, 1, 0);  // en at T+6
    add(0, 0, 0, 4'd0,     1, 1, 16'h0020, 4'd5, 0, 0);
    add(0, 1, 0, 4'd5,     1, 1, 16'h0020, 4'd5, 0, 0);  // same-index select
    add(0, 0, 0, 4'd0,     1, 1, 16'h0020, 4'd5, 1, 0);
    add(0, 1, 1, 4'd0,     0, 0, 16'h0020, 4'd5, 0, 0);  // release
    add(0, 0, 0, 4'd0,     0, 0, 16'h0020, 4'd5, 0, 0);
    add(0, 0, 0, 4'd0,     0, 0, 16'h0020, 4'd5, 0, 0);
    add(0, 0, 0, 4'd0,     1, 0, 16'h0000, 4'd0, 0, 0);
    add(0, 0, 0, 4'd0,     1, 0, 16'h0000, 4'd0, 1, 0);
    add(0, 0, 0, 4'd0,     1, 0, 16'h0000, 4'd0, 0, 0);
    add(0, 1, 0, 4'd9,     1, 0, 16'h0000, 4'd0, 0, 0);  // illegal 9 in IDLE
    add(0, 0, 0, 4'd0,     1, 0, 16'h0000, 4'd0, 0, 1);
    add(0, 0, 0, 4'd0,     1, 0, 16'h0000, 4'd0, 0, 0);
    add(0, 1, 0, 4'd1,     0, 0, 16'h0002, 4'd1, 0, 0);  // select 1
    add(0, 0, 0, 4'd0,     0, 0, 16'h0002, 4'd1, 0, 0);
    add(0, 0, 0, 4'd0,     0, 0, 16'h0002, 4'd1, 0, 0);
    add(0, 0, 0, 4'd0,     1, 1, 16'h0002, 4'd1, 1, 0);
    add(0, 0, 0, 4'd0,     1, 1, 16'h0002, 4'd1, 0, 0);
    add(0, 1, 0, 4'd8,     0, 0, 16'h0002, 4'd1, 0, 0);  // illegal 8 while active
    add(0, 0, 0, 4'd0,     0, 0, 16'h0002, 4'd1, 0, 1);
    add(0, 0, 0, 4'd0,     0, 0, 16'h0002, 4'd1, 0, 0);
    add(0, 0, 0, 4'd0,     1, 0, 16'h0000, 4'd0, 0, 0);
    add(0, 0, 0, 4'd0,     1, 0, 16'h0000, 4'd0, 1, 0);
    add(0, 0, 0, 4'd0,     1, 0, 16'h0000, 4'd0, 0, 0);
    add(0, 1, 1, 4'd3,     1, 0, 16'h0000, 4'd0, 0, 0);  // release in IDLE
    add(0, 0, 0, 4'd0,     1, 0, 16'h0000, 4'd0, 1, 0);
    add(0, 0, 0, 4'd0,     1, 0, 16'h0000, 4'd0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      drive(vecs[i].v, vecs[i].rel, vecs[i].idx);
      step();
      chk($sformatf("vec%0d {rdy,en,act,d,cur,done,err}", i), obs(),
          pack_exp(vecs[i].rdy, vecs[i].en, vecs[i].d, vecs[i].cur, vecs[i].dn, vecs[i].er));
    end

    // sel_valid held through SETUP is consumed only once ACTIVE
    drive(1'b1, 1'b0, 4'd1);
    step();
    chk("held_sel_setup", obs(), pack_exp(0, 0, 16'h0002, 4'd1, 0, 0));
    drive(1'b1, 1'b0, 4'd3);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("held_not_consumed", obs(), pack_exp(0, 0, 16'h0002, 4'd1, 0, 0));
    end
    step();
    chk("held_active_first", obs(), pack_exp(1, 1, 16'h0002, 4'd1, 1, 0));
    step();
    chk("held_taken", obs(), pack_exp(0, 0, 16'h0002, 4'd1, 0, 0));
    drive(1'b0, 1'b0, 4'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("held_hold", obs(), pack_exp(0, 0, 16'h0002, 4'd1, 0, 0));
    end
    step();
    chk("held_bus_move", obs(), pack_exp(0, 0, 16'h0008, 4'd3, 0, 0));
    for (int k = 0; k < 2; k++) begin
      step();
      chk("held_setup2", obs(), pack_exp(0, 0, 16'h0008, 4'd3, 0, 0));
    end
    step();
    chk("held_en_on_3", obs(), pack_exp(1, 1, 16'h0008, 4'd3, 1, 0));

    // Reset while ACTIVE
    reset = 1'b1;
    step();
    chk("rst_active", obs(), pack_exp(0, 0, 16'h0000, 4'd0, 0, 0));
    reset = 1'b0;
    step();
    chk("rst_active_after", obs(), pack_exp(1, 0, 16'h0000, 4'd0, 0, 0));

    // Reset while SETUP: nothing resumes afterwards
    drive(1'b1, 1'b0, 4'd7);
    step();
    chk("rst_setup_sel7", obs(), pack_exp(0, 0, 16'h0080, 4'd7, 0, 0));
    drive(1'b0, 1'b0, 4'd0);
    step();
    reset = 1'b1;
    step();
    chk("rst_setup", obs(), pack_exp(0, 0, 16'h0000, 4'd0, 0, 0));
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rst_setup_quiet", obs(), pack_exp(1, 0, 16'h0000, 4'd0, 0, 0));
    end

    // Random soak on the SETUP=1/HOLD=1 instance
    exp_done = 0; exp_err = 0; seen_done = 0; seen_err = 0;
    prev_d = ifr.d_bus; prev_en = ifr.en;
    for (int c = 0; c < 10000; c++) begin
      ifr.sel_valid   = ($urandom_range(0, 3) != 0);
      ifr.sel_release = ($urandom_range(0, 5) == 0);
      ifr.sel_idx     = 4'($urandom_range(0, 11));
      acc     = ifr.sel_valid && ifr.sel_ready;
      illegal = !ifr.sel_release && (ifr.sel_idx >= 4'd8);
      if (acc) begin
        if (illegal) exp_err++;
        if (!(illegal && !ifr.en)) exp_done++;
      end
      step();
      chk("rnd_onehot", {31'd0, ((ifr.d_bus & (ifr.d_bus - 16'd1)) == 16'd0) && (ifr.d_bus[15:8] == 8'd0)}, 32'd1);
      if (ifr.d_bus != prev_d)
        chk("rnd_bus_change_en", {30'd0, prev_en, ifr.en}, 32'd0);
      chk("rnd_done_err_excl", {31'd0, ifr.done && ifr.err}, 32'd0);
      if (ifr.done) seen_done++;
      if (ifr.err)  seen_err++;
      prev_d  = ifr.d_bus;
      prev_en = ifr.en;
    end
    ifr.sel_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (ifr.done) seen_done++;
      if (ifr.err)  seen_err++;
    end
    chk("rnd_done_count", 32'(seen_done), 32'(exp_done));
    chk("rnd_err_count", 32'(seen_err), 32'(exp_err));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_select_writer.md
Name: uart_select_writer

Overview:
- Host-side driver for the UART channel-selector bus. Drives the same 16-bit data bus and enable strobe that the selector samples.
- Accepts channel select and release commands over a valid/ready handshake and converts each channel index to a one-hot bus word.
- Sequences the enable line with programmable setup and hold guard intervals, so the selector's 2-flop synchronisers never sample a changing bus while enable is high.

Parameters:
- CHANNEL_AMOUNT, 8, number of selectable channels (1..16); indices >= CHANNEL_AMOUNT are illegal.
- SETUP_CYCLES, 3, clk cycles the bus is stable before en rises (>=1).
- HOLD_CYCLES, 3, clk cycles the bus is stable after en falls (>=1).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sel_valid  input  1  command valid
- sel_ready  output  1  command accepted when sel_valid & sel_ready at a rising edge
- sel_release  input  1  1 = deselect command, 0 = select command
- sel_idx  input  4  channel index for select (ignored on release)
- en  output  1  enable strobe to selector
- d_bus  output  16  one-hot channel word to selector
- active  output  1  equals en; a channel is currently enabled
- cur_idx  output  4  index currently driven on d_bus (0 when d_bus = 0)
- done  output  1  one-cycle pulse: command completed
- err  output  1  one-cycle pulse: illegal index received

Behaviour:
- Clock and reset:
  - Single clock, synchronous active-high reset.
  - Reset values: en=0, d_bus=0, cur_idx=0, done=0, err=0, state IDLE, counter 0, pending cleared.
  - Reset mid-operation from any state: en and d_bus are 0 at the first edge with reset high; any pending command is discarded.
- States: IDLE, SETUP, ACTIVE, HOLD.
- sel_ready is 1 in IDLE and ACTIVE only, 0 in SETUP, HOLD and during reset.
- IDLE (en=0, d_bus=0):
  - Legal select accepted at edge T: d_bus = 1<<sel_idx and cur_idx = sel_idx at T; counter loaded with SETUP_CYCLES; go to SETUP.
  - Release accepted: done pulses at T+1; stay in IDLE.
  - Illegal index accepted: err pulses at T+1; no bus change; stay in IDLE.
- SETUP (en=0, d_bus held):
  - Counter decrements each cycle.
  - en rises exactly SETUP_CYCLES edges after d_bus changed; go to ACTIVE on that edge.
  - done pulses during the first ACTIVE cycle.
- ACTIVE (en=1, d_bus held):
  - Select of the same index: accepted, done pulses next cycle, no en toggle, no bus change.
  - Select of a different legal index: accepted at T; en=0 at T; new index stored as pending; counter loaded with HOLD_CYCLES; go to HOLD.
  - Release: same as a different-index select, with no pending index.
  - Illegal index: err pulses at T+1, then handled exactly as a release.
- HOLD (en=0, d_bus held at old value for HOLD_CYCLES cycles):
  - On expiry with a pending index: d_bus = 1<<pending, cur_idx updated, counter = SETUP_CYCLES, go to SETUP.
  - On expiry with no pending index: d_bus=0, cur_idx=0, done pulses next cycle, go to IDLE.
- Invariants:
  - d_bus never changes on the same edge en rises, nor while en=1.
  - d_bus is always 0 or exactly one-hot within bits [CHANNEL_AMOUNT-1:0]; bits above are always 0.
  - done and err never assert in the same cycle; each is exactly one cycle wide.
- Latencies with defaults:
  - Select from IDLE: en rises 3 cycles after acceptance.
  - Channel switch: en low for HOLD+SETUP = 6 cycles.
- sel_valid held high while sel_ready=0 is not consumed. The command is taken on the first ready cycle with its input values at that edge.

Test Plan:
- Reset, then select idx 2 at T -> d_bus=0x0004 at T, en=1 at T+3, done at T+3, active=1, cur_idx=2.
- While active on 2, select idx 5 at T -> en=0 at T, d_bus=0x0004 through T+2, d_bus=0x0020 at T+3, en=1 at T+6, done once. Assert no edge where en=1 and d_bus changes.
- While active on 5, select idx 5 -> done next cycle, en stays 1, d_bus stays 0x0020; then release -> en=0, d_bus=0 after 3 cycles, done, sel_ready=1 in IDLE.
- Select idx 9 in IDLE (CHANNEL_AMOUNT=8) -> err pulse, en=0, d_bus=0. Select idx 8 while active on 1 -> err pulse, then release sequence ending at d_bus=0.
- Hold sel_valid high during SETUP with idx 3 -> not accepted until ACTIVE; then a switch to 3 occurs. Also assert reset during SETUP and during ACTIVE -> en=0, d_bus=0, cur_idx=0 the next edge, state IDLE.
- Back-to-back random commands for 10k cycles with SETUP=1, HOLD=1 -> scoreboard checks the one-hot/zero invariant, the guard intervals, and a single done/err per accepted command.
